fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
Parameters, one per line: name, default, meaning.
REQ-001 SHALL have PC_W, 9, program-counter width in bits.
REQ-002 SHALL have INSTR_W, 33, instruction word width in bits.
REQ-003 SHALL have DEPTH, 4, prefetch queue entries; power of two, at least 2.
REQ-004 SHALL have PC_STEP, 1, PC increment per sequential instruction.
REQ-005 SHALL have RESET_PC, 0, first fetch address after reset.

Ports, one per line: name, direction, width, meaning.
REQ-006 SHALL have clk, in, 1, single clock; all state updates on the rising edge.
REQ-007 SHALL have rst, in, 1, asynchronous active-low reset.
REQ-008 SHALL have PCSrcE, in, 1, redirect request from execute.
REQ-009 SHALL have PCTargetE, in, PC_W, redirect target.
REQ-010 SHALL have StallF, in, 1, decode stall; hold the D-side outputs.
REQ-011 SHALL have imem_addr, out, PC_W, address to the synchronous instruction memory (1-cycle read latency).
REQ-012 SHALL have imem_rdata, in, INSTR_W, memory read data, valid the cycle after the address is sampled.
REQ-013 SHALL have InstrD, out, INSTR_W, instruction to decode.
REQ-014 SHALL have PCD, out, PC_W, PC of InstrD.
REQ-015 SHALL have PCPlus4D, out, PC_W, PCD+PC_STEP.
REQ-016 SHALL have ValidD, out, 1, D-side outputs hold a real instruction; 0 means bubble.

Function
REQ-017 SHALL drive imem_addr combinationally from the fetch PC (PCF).
REQ-018 SHALL issue a fetch in a cycle only if count + inflight - pop < DEPTH, where count is the number of queued entries, inflight is 1 if a fetch was issued last cycle and not killed, and pop is 1 if a dequeue occurs this cycle.
REQ-019 SHALL advance PCF by PC_STEP, modulo 2^PC_W, on each issue; 2^PC_W-1 wraps to 0.
REQ-020 SHALL hold PCF when no issue occurs.
REQ-021 SHALL push {imem_rdata, issued PC} into the queue in the cycle after an un-killed issue.
REQ-022 SHALL perform no issue-to-dequeue bypass: an instruction sampled at edge N reaches InstrD at edge N+2 at the earliest.
REQ-023 SHALL, when StallF=0 and the queue is non-empty, pop the head into InstrD/PCD/PCPlus4D and set ValidD=1.
REQ-024 SHALL, when StallF=0 and the queue is empty, set ValidD=0 and leave InstrD/PCD/PCPlus4D unchanged.
REQ-025 SHALL, when StallF=1 and PCSrcE=0, hold all D-side outputs and pop nothing, while fetch continues under REQ-018.
REQ-026 SHALL give PCSrcE=1 priority over StallF: empty the queue, kill the in-flight response (never pushed), set PCF<=PCTargetE+PC_STEP, issue PCTargetE that cycle (imem_addr=PCTargetE), and set ValidD<=0.
REQ-027 SHALL keep queue pointers of log2(DEPTH) bits with natural wrap and a separate count of log2(DEPTH)+1 bits.
REQ-028 SHALL never overflow or underflow the queue under any input sequence.
REQ-029 SHALL support simultaneous push and pop at count==DEPTH-1 or count==1 with count unchanged.

Reset
REQ-030 SHALL, while rst=0, asynchronously set PCF=RESET_PC, count=0, pointers=0, inflight=0, ValidD=0, InstrD=0, PCD=0, PCPlus4D=0.
REQ-031 SHALL issue RESET_PC at the first edge after rst rises, so the first ValidD=1 appears after the third edge.
REQ-032 SHALL, on reset assertion mid-operation, discard all queued and in-flight data.

Structure
REQ-033 SHALL place the queue-entry struct {instr, pc} and the default parameter constants in shared package fetch_pkg.
REQ-034 SHALL implement the queue storage as sub-module fetch_fifo, with push/pop/flush/count and no bypass.
REQ-035 SHALL keep the issue/credit logic and the D-side register in fetch_queue.

Verification
REQ-036 Reset then free run with StallF=0 and imem_rdata=addr+0x100 SHALL produce ValidD=1 from edge 3, with PCD=0,1,2,3… and InstrD=0x100,0x101… in consecutive cycles.
REQ-037 Holding StallF=1 for 10 cycles after warm-up SHALL hold the outputs, stop issue once count=4 (DEPTH=4), and on release deliver the next 4 PCs back-to-back with none lost or duplicated.
REQ-038 PCSrcE=1 with PCTargetE=0x40 while the queue is full and a fetch is in flight SHALL give imem_addr=0x40 that cycle, ValidD=0 next cycle, and PCD=0x40 two cycles later.
REQ-039 PCSrcE=1 and StallF=1 in the same cycle SHALL apply the redirect per REQ-026, with StallF ignored for the flush.
REQ-040 Starting at PC 0x1FE with PC_W=9 SHALL produce the PCD sequence 0x1FE, 0x1FF, 0x000 and PCPlus4D=0x000 for PCD=0x1FF.
REQ-041 Asserting rst with 3 entries queued SHALL immediately give ValidD=0, and after release the first instruction delivered SHALL be PC=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction prefetch queue.
package fetch_pkg;

    localparam int FQ_PC_W     = 9;
    localparam int FQ_INSTR_W  = 33;
    localparam int FQ_DEPTH    = 4;
    localparam int FQ_PC_STEP  = 1;
    localparam int FQ_RESET_PC = 0;

    // One queued fetch: the returned word and the address it was fetched from.
    typedef struct packed {
        logic [FQ_INSTR_W-1:0] instr;
        logic [FQ_PC_W-1:0]    pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-stage bundle: execute redirect, decode stall/outputs and the imem port.
interface fetch_queue_if
    import fetch_pkg::*;
#(
    parameter int PC_W    = FQ_PC_W,
    parameter int INSTR_W = FQ_INSTR_W
);
    logic               PCSrcE;
    logic [PC_W-1:0]    PCTargetE;
    logic               StallF;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] InstrD;
    logic [PC_W-1:0]    PCD;
    logic [PC_W-1:0]    PCPlus4D;
    logic               ValidD;

    modport master (
        input  PCSrcE, PCTargetE, StallF, imem_rdata,
        output imem_addr, InstrD, PCD, PCPlus4D, ValidD
    );

    modport slave (
        output PCSrcE, PCTargetE, StallF, imem_rdata,
        input  imem_addr, InstrD, PCD, PCPlus4D, ValidD
    );
endinterface

// File: rtl/fetch_fifo.sv
// Prefetch storage: circular buffer with flush; head is only visible once written.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  fetch_entry_t             push_data_i,
    input  logic                     pop_i,
    output fetch_entry_t             head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_push  = push_i && (count_q != CNT_FULL) && !flush_i;
        do_pop   = pop_i && (count_q != '0) && !flush_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            count_d = count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: credit-based issue to a 1-cycle imem, prefetch queue, decode register.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int PC_W     = FQ_PC_W,
    parameter int INSTR_W  = FQ_INSTR_W,
    parameter int DEPTH    = FQ_DEPTH,
    parameter int PC_STEP  = FQ_PC_STEP,
    parameter int RESET_PC = FQ_RESET_PC
) (
    input logic           clk,
    input logic           rst,
    fetch_queue_if.master bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [PC_W-1:0] STEP    = PC_W'(PC_STEP);
    localparam logic [PC_W-1:0] PC_INIT = PC_W'(RESET_PC);

    logic [PC_W-1:0]    pcf_q, pcf_d;
    logic               inflight_q, inflight_d;
    logic [PC_W-1:0]    infl_pc_q, infl_pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    pcd_q, pcd_d, pcp_q, pcp_d;
    logic               valid_q, valid_d;
    logic               redirect, pop, push, issue, empty;
    logic [PC_W-1:0]    fetch_addr;
    logic [CNT_W-1:0]   count;
    fetch_entry_t       head, wr_entry;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect),
        .push_i      (push),
        .push_data_i (wr_entry),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count),
        .empty_o     (empty)
    );

    always_comb begin
        redirect = bus.PCSrcE;
        pop      = !redirect && !bus.StallF && !empty;
        // A redirected response is dropped here, so it never reaches the queue.
        push     = inflight_q && !redirect;
        wr_entry = '{instr: bus.imem_rdata, pc: infl_pc_q};
        if (redirect) issue = 1'b1;
        else          issue = (int'(count) + int'(inflight_q) - int'(pop)) < DEPTH;
        fetch_addr = redirect ? bus.PCTargetE : pcf_q;
        pcf_d      = issue ? fetch_addr + STEP : pcf_q;
        inflight_d = issue;
        infl_pc_d  = fetch_addr;

        instr_d = instr_q;
        pcd_d   = pcd_q;
        pcp_d   = pcp_q;
        valid_d = valid_q;
        if (redirect) begin
            valid_d = 1'b0;
        end else if (!bus.StallF) begin
            valid_d = pop;
            if (pop) begin
                instr_d = head.instr;
                pcd_d   = head.pc;
                pcp_d   = head.pc + STEP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcf_q      <= PC_INIT;
            inflight_q <= 1'b0;
            infl_pc_q  <= '0;
            instr_q    <= '0;
            pcd_q      <= '0;
            pcp_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            pcf_q      <= pcf_d;
            inflight_q <= inflight_d;
            infl_pc_q  <= infl_pc_d;
            instr_q    <= instr_d;
            pcd_q      <= pcd_d;
            pcp_q      <= pcp_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.imem_addr = fetch_addr;
    assign bus.InstrD    = instr_q;
    assign bus.PCD       = pcd_q;
    assign bus.PCPlus4D  = pcp_q;
    assign bus.ValidD    = valid_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random stall/redirect against a queue model.
module tb_fetch_queue;
    localparam int PC_W    = 9;
    localparam int INSTR_W = 33;
    localparam int DEPTH   = 4;
    localparam int PC_MOD  = 512;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_queue_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    fetch_queue #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .PC_STEP(1), .RESET_PC(0)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Synchronous instruction memory: word = address + 0x100.
    always @(posedge clk) bus.imem_rdata <= INSTR_W'(bus.imem_addr) + INSTR_W'('h100);

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: fetch PC, outstanding fetch, and FIFO of fetched PCs.
    int     m_q[$];
    int     m_pcf, m_infl, m_infl_pc, m_valid, m_pcd, m_pcp;
    longint m_instr;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pcf = 0; m_infl = 0; m_infl_pc = 0;
        m_valid = 0; m_pcd = 0; m_pcp = 0; m_instr = 0;
    endtask

    // One clock cycle with given inputs; checks imem_addr mid-cycle and D-side after the edge.
    task automatic cyc(input bit src, input int tgt, input bit stall);
        int addr;
        bit pop, issue;
        bus.PCSrcE    = src;
        bus.PCTargetE = PC_W'(tgt);
        bus.StallF    = stall;
        #1;
        addr = src ? tgt : m_pcf;
        check_eq("imem_addr", longint'(bus.imem_addr), addr);
        pop   = !src && !stall && (m_q.size() > 0);
        issue = src || ((m_q.size() + m_infl - int'(pop)) < DEPTH);
        if (src) m_valid = 0;
        else if (!stall) begin
            if (m_q.size() > 0) begin
                m_pcd   = m_q.pop_front();
                m_valid = 1;
                m_instr = m_pcd + 'h100;
                m_pcp   = (m_pcd + 1) % PC_MOD;
            end else m_valid = 0;
        end
        if (src) m_q.delete();
        else if (m_infl != 0) m_q.push_back(m_infl_pc);
        if (m_q.size() > DEPTH) check_eq("model_overflow", m_q.size(), DEPTH);
        m_infl    = issue ? 1 : 0;
        m_infl_pc = addr;
        if (issue) m_pcf = (addr + 1) % PC_MOD;
        @(posedge clk);
        #1;
        check_eq("ValidD",   longint'(bus.ValidD),   m_valid);
        check_eq("PCD",      longint'(bus.PCD),      m_pcd);
        check_eq("PCPlus4D", longint'(bus.PCPlus4D), m_pcp);
        check_eq("InstrD",   longint'(bus.InstrD),   m_instr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int held, cnt;
        bus.PCSrcE = 1'b0; bus.PCTargetE = '0; bus.StallF = 1'b0;
        model_reset();
        #3;
        check_eq("rst_valid", bus.ValidD, 0);
        check_eq("rst_pcd",   bus.PCD, 0);
        check_eq("rst_instr", bus.InstrD, 0);
        check_eq("rst_pcp",   bus.PCPlus4D, 0);
        check_eq("rst_addr",  bus.imem_addr, 0);
        @(posedge clk); #1; rst = 1'b1;

        // Boot: first valid instruction after the third edge.
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        check_eq("boot_edge2_valid", bus.ValidD, 0);
        cyc(0, 0, 0);
        check_eq("boot_edge3_valid", bus.ValidD, 1);
        check_eq("boot_edge3_pcd",   bus.PCD, 0);
        check_eq("boot_edge3_instr", bus.InstrD, 'h100);
        for (int i = 1; i < 8; i++) begin
            cyc(0, 0, 0);
            check_eq("stream_pcd", bus.PCD, i);
        end

        // Long stall: outputs hold, queue fills and issue stops, then drains in order.
        held = m_pcd;
        for (int i = 0; i < 10; i++) cyc(0, 0, 1);
        check_eq("stall_hold_pcd", bus.PCD, held);
        check_eq("stall_queue_full", m_q.size(), DEPTH);
        for (int i = 1; i <= 4; i++) begin
            cyc(0, 0, 0);
            check_eq("drain_valid", bus.ValidD, 1);
            check_eq("drain_pcd",   bus.PCD, (held + i) % PC_MOD);
        end
        for (int i = 0; i < 3; i++) cyc(0, 0, 0);

        // Redirect with the queue effectively full and a fetch outstanding.
        cnt = 0;
        while (!(m_q.size() == DEPTH - 1 && m_infl != 0) && cnt < 8) begin
            cyc(0, 0, 1);
            cnt++;
        end
        check_eq("redir_setup_reached", (m_q.size() == DEPTH - 1 && m_infl != 0) ? 1 : 0, 1);
        cyc(1, 'h40, 0);
        check_eq("redir_valid0", bus.ValidD, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        check_eq("redir_pcd", bus.PCD, 'h40);
        check_eq("redir_valid1", bus.ValidD, 1);

        // Redirect while stalled: the flush wins.
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        cyc(1, 'h80, 1);
        check_eq("redir_stall_valid0", bus.ValidD, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        check_eq("redir_stall_pcd", bus.PCD, 'h80);

        // PC wrap at the top of the address space.
        cyc(1, 'h1FE, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        check_eq("wrap_pcd0", bus.PCD, 'h1FE);
        cyc(0, 0, 0);
        check_eq("wrap_pcd1", bus.PCD, 'h1FF);
        check_eq("wrap_pcp1", bus.PCPlus4D, 'h000);
        cyc(0, 0, 0);
        check_eq("wrap_pcd2", bus.PCD, 'h000);

        // Random stall/redirect traffic.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 99) < 6) ? 1'b1 : 1'b0,
                int'($urandom_range(0, PC_MOD - 1)),
                ($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0);
        end

        // Reset mid-operation with three entries queued.
        for (int i = 0; i < 4; i++) cyc(0, 0, 0);
        cnt = 0;
        while (m_q.size() != 3 && cnt < 10) begin
            cyc(0, 0, 1);
            cnt++;
        end
        check_eq("mrst_setup_q3", m_q.size(), 3);
        #2;
        rst = 1'b0;
        #1;
        check_eq("mrst_valid", bus.ValidD, 0);
        check_eq("mrst_addr",  bus.imem_addr, 0);
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        cnt = 0;
        while (bus.ValidD !== 1'b1 && cnt < 6) begin
            cyc(0, 0, 0);
            cnt++;
        end
        check_eq("mrst_first_edges", cnt, 3);
        check_eq("mrst_first_pcd",   bus.PCD, 0);
        check_eq("mrst_first_instr", bus.InstrD, 'h100);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
